// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS controller: FSM states, opcode classes,
// ALU function codes and the pc_src / wb_sel select encodings.
package mips_mc_pkg;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4
   } stateT;

   localparam logic [2:0] CLS_ALU_RR = 3'd0;
   localparam logic [2:0] CLS_ALU_RI = 3'd1;
   localparam logic [2:0] CLS_MEM    = 3'd2;
   localparam logic [2:0] CLS_SHIFT  = 3'd3;
   localparam logic [2:0] CLS_JMP    = 3'd4;
   localparam logic [2:0] CLS_BRANCH = 3'd5;
   localparam logic [2:0] CLS_NONE   = 3'd7;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;

   localparam logic [1:0] PC_SRC_NEXT   = 2'b00;
   localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

   localparam logic [1:0] WB_SEL_ALU   = 2'b00;
   localparam logic [1:0] WB_SEL_MEM   = 2'b01;
   localparam logic [1:0] WB_SEL_SHIFT = 2'b10;

   // Classes whose EXEC result goes straight to the register file.
   function automatic logic hasWriteBack(input logic [2:0] cls);
      return (cls == CLS_ALU_RR) || (cls == CLS_ALU_RI) || (cls == CLS_SHIFT);
   endfunction

endpackage

// File: rtl/mips_mc_decode.sv
// Combinational opcode decode: the 5-bit opcode field (instr[18:14]) to class and op sub-fields.
module mips_mc_decode
   import mips_mc_pkg::*;
(
   input  logic [4:0] opcode,
   output logic [2:0] opClass,
   output logic [2:0] aluOp,
   output logic [1:0] shroOp,
   output logic       isStore,
   output logic       brOnCarry
);

   // Class from the top bits; sub-fields are plain slices of the opcode.
   always_comb begin
      opClass = CLS_NONE;
      case (opcode[4:3])
         2'b00:   opClass = CLS_ALU_RR;
         2'b01:   opClass = CLS_ALU_RI;
         2'b10:   opClass = opcode[2] ? CLS_SHIFT : CLS_MEM;
         2'b11:   opClass = opcode[2] ? CLS_BRANCH : CLS_JMP;
         default: opClass = CLS_NONE;
      endcase
      aluOp     = opcode[2:0];
      shroOp    = opcode[1:0];
      isStore   = opcode[1];
      brOnCarry = opcode[1];
   end

endmodule

// File: rtl/mips_multi_cycle_controller.sv
// Moore sequencer for the 19-bit dataPath: FETCH/DECODE/EXEC/MEM/WB.
// Define MEM_READY_EN to add the mem_ready handshake that stretches FETCH and MEM.
module mips_multi_cycle_controller
   import mips_mc_pkg::*;
#(
   parameter int INSTR_W  = 19,
   parameter int ALU_OP_W = 3
)(
   input  logic                clk,
   input  logic                rst,
   input  logic [INSTR_W-1:0]  instr,
   input  logic                zero_flag,
   input  logic                carry_flag,
`ifdef MEM_READY_EN
   input  logic                mem_ready,
`endif
   output logic                ir_write,
   output logic                pc_en,
   output logic [1:0]          pc_src,
   output logic                reg_write,
   output logic [1:0]          wb_sel,
   output logic                sel_r2,
   output logic                alu_b_sel,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic [1:0]          shro_op,
   output logic                mem_read,
   output logic                mem_write,
   output logic                c_en,
   output logic                z_en,
   output logic                instr_done
);

   stateT       stateR, nextStateS;
   logic        runR;
   logic [2:0]  classR, decClassS;
   logic [2:0]  aluOpR, decAluOpS;
   logic [1:0]  shroOpR, decShroOpS;
   logic        isStoreR, decIsStoreS;
   logic        brCarryR, decBrCarryS;
   logic        memDoneS;
   logic        unusedInstrBits;

`ifdef MEM_READY_EN
   assign memDoneS = mem_ready;
`else
   assign memDoneS = 1'b1;
`endif

   assign unusedInstrBits = ^instr[INSTR_W-6:0];

   mips_mc_decode uDecode (
      .opcode    (instr[INSTR_W-1 -: 5]),
      .opClass   (decClassS),
      .aluOp     (decAluOpS),
      .shroOp    (decShroOpS),
      .isStore   (decIsStoreS),
      .brOnCarry (decBrCarryS)
   );

   // State register; runR keeps every output low during reset and until the first edge after release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stateR <= FETCH;
         runR   <= 1'b0;
      end else begin
         runR <= 1'b1;
         if (runR) stateR <= nextStateS;
         else      stateR <= FETCH;
      end
   end

   // Class and op fields captured in DECODE so later IR changes cannot redirect the sequence.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         classR   <= CLS_NONE;
         aluOpR   <= ALU_ADD;
         shroOpR  <= 2'b00;
         isStoreR <= 1'b0;
         brCarryR <= 1'b0;
      end else if (runR && (stateR == DECODE)) begin
         classR   <= decClassS;
         aluOpR   <= decAluOpS;
         shroOpR  <= decShroOpS;
         isStoreR <= decIsStoreS;
         brCarryR <= decBrCarryS;
      end
   end

   // Next-state selection; anything unrecognised falls back to FETCH.
   always_comb begin
      nextStateS = FETCH;
      case (stateR)
         FETCH:  nextStateS = memDoneS ? DECODE : FETCH;
         DECODE: nextStateS = EXEC;
         EXEC: begin
            if (hasWriteBack(classR))   nextStateS = WB;
            else if (classR == CLS_MEM) nextStateS = MEM;
            else                        nextStateS = FETCH;
         end
         MEM: begin
            if (!memDoneS)    nextStateS = MEM;
            else if (isStoreR) nextStateS = FETCH;
            else              nextStateS = WB;
         end
         WB:      nextStateS = FETCH;
         default: nextStateS = FETCH;
      endcase
   end

   // Output decode from the registered state; only branch pc_en looks at the flags.
   always_comb begin
      ir_write   = 1'b0;
      pc_en      = 1'b0;
      pc_src     = PC_SRC_NEXT;
      reg_write  = 1'b0;
      wb_sel     = WB_SEL_ALU;
      sel_r2     = 1'b0;
      alu_b_sel  = 1'b0;
      alu_op     = '0;
      shro_op    = 2'b00;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      c_en       = 1'b0;
      z_en       = 1'b0;
      instr_done = 1'b0;
      if (runR) begin
         case (stateR)
            FETCH: begin
               ir_write = memDoneS;
               pc_en    = memDoneS;
            end
            EXEC: begin
               case (classR)
                  CLS_ALU_RR, CLS_ALU_RI: begin
                     alu_op    = ALU_OP_W'(aluOpR);
                     alu_b_sel = (classR == CLS_ALU_RI);
                     c_en      = 1'b1;
                     z_en      = 1'b1;
                  end
                  CLS_MEM: begin
                     alu_op    = ALU_OP_W'(ALU_ADD);
                     alu_b_sel = 1'b1;
                  end
                  CLS_SHIFT: shro_op = shroOpR;
                  CLS_JMP: begin
                     pc_en      = 1'b1;
                     pc_src     = PC_SRC_JUMP;
                     instr_done = 1'b1;
                  end
                  CLS_BRANCH: begin
                     pc_en      = brCarryR ? carry_flag : zero_flag;
                     pc_src     = PC_SRC_BRANCH;
                     instr_done = 1'b1;
                  end
                  default: instr_done = 1'b0;
               endcase
            end
            MEM: begin
               if (isStoreR) begin
                  mem_write  = 1'b1;
                  sel_r2     = 1'b1;
                  instr_done = memDoneS;
               end else begin
                  mem_read = 1'b1;
               end
            end
            WB: begin
               reg_write  = 1'b1;
               instr_done = 1'b1;
               case (classR)
                  CLS_MEM:   wb_sel = WB_SEL_MEM;
                  CLS_SHIFT: wb_sel = WB_SEL_SHIFT;
                  default:   wb_sel = WB_SEL_ALU;
               endcase
            end
            default: instr_done = 1'b0;
         endcase
      end else begin
         pc_src = PC_SRC_NEXT;
         wb_sel = WB_SEL_ALU;
      end
   end

endmodule

// File: tb/tb_mips_multi_cycle_controller.sv
// Scoreboard bench: the driver pushes the expected control word for every cycle, a monitor pops and compares.
module tb_mips_multi_cycle_controller;

   typedef struct packed {
      logic       irWrite;
      logic       pcEn;
      logic [1:0] pcSrc;
      logic       regWrite;
      logic [1:0] wbSel;
      logic       selR2;
      logic       aluBSel;
      logic [2:0] aluOp;
      logic [1:0] shroOp;
      logic       memRead;
      logic       memWrite;
      logic       cEn;
      logic       zEn;
      logic       instrDone;
   } ctrlVecT;

   logic        clk = 1'b0;
   logic        rst;
   logic [18:0] instr;
   logic        zeroFlag, carryFlag;
`ifdef MEM_READY_EN
   logic        memReady;
`endif
   logic        irWrite, pcEn, regWrite, selR2, aluBSel, memRead, memWrite, cEn, zEn, instrDone;
   logic [1:0]  pcSrc, wbSel, shroOp;
   logic [2:0]  aluOp;

   ctrlVecT gotVec;
   ctrlVecT expQ[$];
   string   tagQ[$];
   int      nChecks = 0;
   int      nFails = 0;
   bit      checkEn = 1'b0;
   int      flagMode = 0;

   always #5 clk = ~clk;

   mips_multi_cycle_controller dut (
      .clk        (clk),
      .rst        (rst),
      .instr      (instr),
      .zero_flag  (zeroFlag),
      .carry_flag (carryFlag),
`ifdef MEM_READY_EN
      .mem_ready  (memReady),
`endif
      .ir_write   (irWrite),
      .pc_en      (pcEn),
      .pc_src     (pcSrc),
      .reg_write  (regWrite),
      .wb_sel     (wbSel),
      .sel_r2     (selR2),
      .alu_b_sel  (aluBSel),
      .alu_op     (aluOp),
      .shro_op    (shroOp),
      .mem_read   (memRead),
      .mem_write  (memWrite),
      .c_en       (cEn),
      .z_en       (zEn),
      .instr_done (instrDone)
   );

   assign gotVec = {irWrite, pcEn, pcSrc, regWrite, wbSel, selR2, aluBSel, aluOp, shroOp,
                    memRead, memWrite, cEn, zEn, instrDone};

   // Monitor: one comparison per negative clock edge and one at the instant reset is asserted.
   initial begin : monitor
      ctrlVecT e;
      string   t;
      forever begin
         @(negedge clk or negedge rst);
         #1;
         if (checkEn) begin
            nChecks++;
            if (expQ.size() == 0) begin
               nFails++;
               $display("FAIL scoreboard-empty: got %h, required an expectation to be queued", gotVec);
            end else begin
               e = expQ.pop_front();
               t = tagQ.pop_front();
               if (gotVec !== e) begin
                  nFails++;
                  $display("FAIL %s: got %h required %h (t=%0t)", t, gotVec, e, $time);
               end
            end
         end
      end
   end

   task automatic push(input ctrlVecT e, input string t);
      expQ.push_back(e);
      tagQ.push_back(t);
   endtask

   task automatic setFlags();
      case (flagMode)
         1:       begin zeroFlag = 1'b1; carryFlag = 1'b0; end
         2:       begin zeroFlag = 1'b0; carryFlag = 1'b1; end
         default: begin zeroFlag = 1'($urandom); carryFlag = 1'($urandom); end
      endcase
   endtask

   task automatic driveReady(output bit rdy);
`ifdef MEM_READY_EN
      memReady = ($urandom_range(0, 2) != 0);
      rdy = memReady;
`else
      rdy = 1'b1;
`endif
   endtask

   // Reference EXEC-cycle control word, straight from the instruction-class rules.
   function automatic ctrlVecT expExec(input logic [18:0] ins, input logic zf, input logic cf);
      ctrlVecT e = '0;
      if (ins[18] == 1'b0) begin
         e.aluOp = ins[16:14]; e.cEn = 1'b1; e.zEn = 1'b1; e.aluBSel = ins[17];
      end else if (ins[17:16] == 2'b00) begin
         e.aluBSel = 1'b1;
      end else if (ins[17:16] == 2'b01) begin
         e.shroOp = ins[15:14];
      end else if (ins[17:16] == 2'b10) begin
         e.pcEn = 1'b1; e.pcSrc = 2'b10; e.instrDone = 1'b1;
      end else begin
         e.pcSrc = 2'b01; e.pcEn = ins[15] ? cf : zf; e.instrDone = 1'b1;
      end
      return e;
   endfunction

   task automatic holdReset(input int n);
      rst = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
         push('0, "in-reset");
      end
      @(negedge clk); #3;
      rst = 1'b1;
   endtask

   task automatic runInstr(input logic [18:0] ins, input bit abortMem);
      ctrlVecT e;
      bit rdy, isMemCls, isLoad, wb;
      isMemCls = (ins[18:16] == 3'b100);
      isLoad   = isMemCls && !ins[15];
      wb       = !ins[18] || (ins[18:16] == 3'b101) || isLoad;
      do begin
         @(posedge clk); #1;
         instr = ins; setFlags(); driveReady(rdy);
         e = '0; e.irWrite = rdy; e.pcEn = rdy;
         push(e, "fetch");
      end while (!rdy);
      @(posedge clk); #1;
      setFlags();
      push('0, "decode");
      @(posedge clk); #1;
      instr = 19'($urandom); setFlags();
      push(expExec(ins, zeroFlag, carryFlag), "exec");
      if (isMemCls) begin
         do begin
            @(posedge clk); #1;
            setFlags(); driveReady(rdy);
            e = '0;
            if (isLoad) e.memRead = 1'b1;
            else begin e.memWrite = 1'b1; e.selR2 = 1'b1; e.instrDone = rdy; end
            push(e, isLoad ? "ldm-mem" : "stm-mem");
            if (abortMem) begin
               @(negedge clk); #3;
               push('0, "reset-abort");
               holdReset(2);
               return;
            end
         end while (!rdy);
      end
      if (wb) begin
         @(posedge clk); #1;
         setFlags();
         e = '0; e.regWrite = 1'b1; e.instrDone = 1'b1;
         e.wbSel = isLoad ? 2'b01 : (ins[18] ? 2'b10 : 2'b00);
         push(e, "wb");
      end
   endtask

   initial begin : driver
      rst = 1'b0; instr = '0; zeroFlag = 1'b0; carryFlag = 1'b0;
`ifdef MEM_READY_EN
      memReady = 1'b1;
`endif
      @(posedge clk); #1;
      checkEn = 1'b1;
      push('0, "reset");
      holdReset(2);

      runInstr({5'b00000, 14'h0000}, 1'b0);             // ADD reg-reg
      runInstr({5'b01011, 14'($urandom)}, 1'b0);        // ALU reg-imm
      flagMode = 1; runInstr({5'b11100, 14'($urandom)}, 1'b0);  // BZ taken
      flagMode = 2; runInstr({5'b11100, 14'($urandom)}, 1'b0);  // BZ not taken
      flagMode = 1; runInstr({5'b11110, 14'($urandom)}, 1'b0);  // BC not taken
      flagMode = 2; runInstr({5'b11110, 14'($urandom)}, 1'b0);  // BC taken
      flagMode = 0;
      runInstr({5'b11000, 14'($urandom)}, 1'b0);        // JMP
      runInstr({5'b10110, 14'($urandom)}, 1'b0);        // shift op 10
      runInstr({5'b10000, 14'($urandom)}, 1'b0);        // LDM
      runInstr({5'b10010, 14'($urandom)}, 1'b0);        // STM
      runInstr({5'b10000, 14'($urandom)}, 1'b1);        // LDM aborted by reset in MEM
      runInstr({5'b00000, 14'h0000}, 1'b0);

      for (int i = 0; i < 300; i++) begin
         runInstr(19'($urandom), ($urandom_range(0, 24) == 0));
      end

      @(negedge clk); #3;
      checkEn = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
